// File: rtl/pe_array_ctl.sv
// Sequencer for the Life PE array: cell writes, one-cycle clear, and paced generation runs.
// Optional macro PE_CTL_STABLE_STOP_EN ends a run early once the array reports no activity.

`ifndef PE_STATE_BITS
`define PE_STATE_BITS 1
`endif
`ifndef PE_STATE_DEAD
`define PE_STATE_DEAD 1'b0
`endif
`ifndef PE_STATE_LIVE
`define PE_STATE_LIVE 1'b1
`endif
`ifndef PE_CMD_BITS
`define PE_CMD_BITS 2
`endif
`ifndef PE_CMD_NOP
`define PE_CMD_NOP 2'd0
`endif
`ifndef PE_CMD_WRITE
`define PE_CMD_WRITE 2'd1
`endif
`ifndef PE_CMD_PROCESS
`define PE_CMD_PROCESS 2'd2
`endif

module pe_array_ctl #(
  parameter int unsigned ROWS     = 8,
  parameter int unsigned COLS     = 8,
  parameter int unsigned GEN_W    = 16,
  parameter int unsigned PERIOD_W = 24
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [$clog2(ROWS)-1:0]    wr_row,
  input  logic [$clog2(COLS)-1:0]    wr_col,
  input  logic [`PE_STATE_BITS-1:0]  wr_state,
  input  logic                       clear,
  input  logic                       start,
  input  logic                       stop,
  input  logic [GEN_W-1:0]           num_gens,
  input  logic [PERIOD_W-1:0]        period,
  input  logic [$clog2(ROWS)-1:0]    rd_row,
  input  logic [$clog2(COLS)-1:0]    rd_col,
  input  logic                       any_active,
  output logic [`PE_CMD_BITS-1:0]    cmd,
  output logic [ROWS-1:0]            rsel_i,
  output logic [COLS-1:0]            csel_i,
  output logic [`PE_STATE_BITS-1:0]  state_in,
  output logic [ROWS-1:0]            rsel_o,
  output logic [COLS-1:0]            csel_o,
  output logic                       busy,
  output logic                       done,
  output logic [GEN_W-1:0]           gen_count,
  output logic                       stable
);

  typedef enum logic [2:0] {StIdle, StWrite, StClear, StStep, StWait, StDone} state_e;

  state_e                      state_q, state_d;
  logic [`PE_CMD_BITS-1:0]     cmd_q, cmd_d;
  logic [ROWS-1:0]             rsel_q, rsel_d;
  logic [COLS-1:0]             csel_q, csel_d;
  logic [`PE_STATE_BITS-1:0]   state_in_q, state_in_d;
  logic [GEN_W-1:0]            gen_q, gen_d, gen_inc;
  logic [GEN_W-1:0]            num_gens_q, num_gens_d;
  logic [PERIOD_W-1:0]         period_q, period_d;
  logic [PERIOD_W-1:0]         wait_q, wait_d;
  logic                        stable_q, stable_d;
  logic                        stable_hit;
  logic                        accept;

  // Out-of-range indices match no bit, giving an all-zero select.
  function automatic logic [ROWS-1:0] dec_row(input logic [$clog2(ROWS)-1:0] idx);
    logic [ROWS-1:0] d;
    for (int unsigned i = 0; i < ROWS; i++) d[i] = (32'(idx) == i);
    return d;
  endfunction

  function automatic logic [COLS-1:0] dec_col(input logic [$clog2(COLS)-1:0] idx);
    logic [COLS-1:0] d;
    for (int unsigned i = 0; i < COLS; i++) d[i] = (32'(idx) == i);
    return d;
  endfunction

`ifdef PE_CTL_STABLE_STOP_EN
  assign stable_hit = !any_active;
`else
  logic unused_any_active;
  assign unused_any_active = any_active;
  assign stable_hit        = 1'b0;
`endif

  assign wr_ready = (state_q == StIdle) && !clear && !start;
  assign accept   = wr_valid && wr_ready;
  assign gen_inc  = (gen_q == '1) ? gen_q : gen_q + GEN_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cmd_q      <= `PE_CMD_NOP;
      rsel_q     <= '0;
      csel_q     <= '0;
      state_in_q <= `PE_STATE_DEAD;
      gen_q      <= '0;
      num_gens_q <= '0;
      period_q   <= '0;
      wait_q     <= '0;
      stable_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      rsel_q     <= rsel_d;
      csel_q     <= csel_d;
      state_in_q <= state_in_d;
      gen_q      <= gen_d;
      num_gens_q <= num_gens_d;
      period_q   <= period_d;
      wait_q     <= wait_d;
      stable_q   <= stable_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      StIdle: begin
        if (clear)       state_d = StClear;
        else if (start)  state_d = StStep;
        else if (accept) state_d = StWrite;
      end
      StWrite, StClear: state_d = StIdle;
      StStep: begin
        wait_d = period_q;
        if ((num_gens_q != '0) && (gen_inc == num_gens_q)) state_d = StDone;
        else if (stop)                                     state_d = StDone;
        else if (stable_hit)                               state_d = StDone;
        else if (period_q == '0)                           state_d = StStep;
        else                                               state_d = StWait;
      end
      StWait: begin
        if (stop)                      state_d = StDone;
        else if (wait_q <= PERIOD_W'(1)) state_d = StStep;
        else                           wait_d  = wait_q - PERIOD_W'(1);
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Registered array outputs are computed from the state being entered.
  always_comb begin
    cmd_d      = `PE_CMD_NOP;
    rsel_d     = '0;
    csel_d     = '0;
    state_in_d = state_in_q;
    gen_d      = gen_q;
    stable_d   = stable_q;
    num_gens_d = num_gens_q;
    period_d   = period_q;
    case (state_d)
      StWrite: begin
        cmd_d      = `PE_CMD_WRITE;
        rsel_d     = dec_row(wr_row);
        csel_d     = dec_col(wr_col);
        state_in_d = wr_state;
      end
      StClear: begin
        cmd_d      = `PE_CMD_WRITE;
        rsel_d     = '1;
        csel_d     = '1;
        state_in_d = `PE_STATE_DEAD;
      end
      StStep:  cmd_d = `PE_CMD_PROCESS;
      default: ;
    endcase
    if ((state_q == StIdle) && start && !clear) begin
      num_gens_d = num_gens;
      period_d   = period;
      gen_d      = '0;
      stable_d   = 1'b0;
    end
    if (state_q == StStep) begin
      gen_d = gen_inc;
      if (stable_hit) stable_d = 1'b1;
    end
  end

  assign cmd       = cmd_q;
  assign rsel_i    = rsel_q;
  assign csel_i    = csel_q;
  assign state_in  = state_in_q;
  assign rsel_o    = dec_row(rd_row);
  assign csel_o    = dec_col(rd_col);
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign gen_count = gen_q;
  assign stable    = stable_q;

endmodule

// File: tb/tb_pe_array_ctl.sv
// Directed bench for pe_array_ctl: per-cycle vector table plus run/reset/stable sequences.
// Follows PE_CTL_STABLE_STOP_EN to pick the expected early-stop behaviour.

`ifndef PE_STATE_BITS
`define PE_STATE_BITS 1
`endif
`ifndef PE_STATE_DEAD
`define PE_STATE_DEAD 1'b0
`endif
`ifndef PE_STATE_LIVE
`define PE_STATE_LIVE 1'b1
`endif
`ifndef PE_CMD_BITS
`define PE_CMD_BITS 2
`endif
`ifndef PE_CMD_NOP
`define PE_CMD_NOP 2'd0
`endif
`ifndef PE_CMD_WRITE
`define PE_CMD_WRITE 2'd1
`endif
`ifndef PE_CMD_PROCESS
`define PE_CMD_PROCESS 2'd2
`endif

module tb_pe_array_ctl;
  localparam int SB = `PE_STATE_BITS;
  localparam int CB = `PE_CMD_BITS;
  localparam logic [SB-1:0] D = `PE_STATE_DEAD;
  localparam logic [SB-1:0] L = `PE_STATE_LIVE;
  localparam logic [CB-1:0] N = `PE_CMD_NOP;
  localparam logic [CB-1:0] W = `PE_CMD_WRITE;
  localparam logic [CB-1:0] P = `PE_CMD_PROCESS;

  logic clk = 1'b0, rst_n;
  logic wr_valid, wr_ready, clear, start, stop, any_active, busy, done, stable;
  logic [2:0] wr_row, wr_col, rd_row, rd_col;
  logic [SB-1:0] wr_state, state_in;
  logic [15:0] num_gens, gen_count;
  logic [23:0] period;
  logic [CB-1:0] cmd;
  logic [7:0] rsel_i, csel_i, rsel_o, csel_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pe_array_ctl dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_row(wr_row), .wr_col(wr_col), .wr_state(wr_state), .clear(clear),
    .start(start), .stop(stop), .num_gens(num_gens), .period(period),
    .rd_row(rd_row), .rd_col(rd_col), .any_active(any_active), .cmd(cmd),
    .rsel_i(rsel_i), .csel_i(csel_i), .state_in(state_in), .rsel_o(rsel_o),
    .csel_o(csel_o), .busy(busy), .done(done), .gen_count(gen_count), .stable(stable)
  );

  typedef struct {
    logic          wv;
    logic [2:0]    row, col;
    logic [SB-1:0] ws;
    logic          clr, st;
    logic [15:0]   ng;
    logic [23:0]   per;
    logic          e_rdy;
    logic [CB-1:0] e_cmd;
    logic [7:0]    e_rsel, e_csel;
    logic [SB-1:0] e_sin;
    logic          e_busy, e_done;
    logic [15:0]   e_gen;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pk(input logic rdy, input logic [CB-1:0] c,
                                     input logic [7:0] rs, input logic [7:0] cs,
                                     input logic [SB-1:0] si, input logic b,
                                     input logic d, input logic [15:0] g);
    return 64'({rdy, c, rs, cs, si, b, d, g});
  endfunction

  task automatic idle_inputs();
    wr_valid = 1'b0; wr_row = '0; wr_col = '0; wr_state = D;
    clear = 1'b0; start = 1'b0; stop = 1'b0; num_gens = '0; period = '0;
    any_active = 1'b1;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic kick(input logic [15:0] ng, input logic [23:0] per);
    @(negedge clk);
    num_gens = ng; period = per; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
  endtask

  initial begin
    logic [CB-1:0] seq_a [7];
    logic [CB-1:0] seq_c [3];
    int nproc;
    logic seen;

    seq_a[0] = P; seq_a[1] = N; seq_a[2] = N; seq_a[3] = P;
    seq_a[4] = N; seq_a[5] = N; seq_a[6] = P;
    seq_c[0] = P; seq_c[1] = N; seq_c[2] = P;

    //          wv row col ws clr st ng per | rdy cmd rsel  csel  sin busy done gen
    tbl[0]  = '{0, 0, 0, D, 0, 0, 0, 0,  1, N, 8'h00, 8'h00, D, 0, 0, 0};
    tbl[1]  = '{1, 2, 5, L, 0, 0, 0, 0,  1, N, 8'h00, 8'h00, D, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, D, 0, 0, 0, 0,  0, W, 8'h04, 8'h20, L, 1, 0, 0};
    tbl[3]  = '{0, 0, 0, D, 0, 0, 0, 0,  1, N, 8'h00, 8'h00, L, 0, 0, 0};
    tbl[4]  = '{1, 1, 1, L, 1, 0, 0, 0,  0, N, 8'h00, 8'h00, L, 0, 0, 0};
    tbl[5]  = '{1, 1, 1, L, 0, 0, 0, 0,  0, W, 8'hFF, 8'hFF, D, 1, 0, 0};
    tbl[6]  = '{1, 1, 1, L, 0, 0, 0, 0,  1, N, 8'h00, 8'h00, D, 0, 0, 0};
    tbl[7]  = '{0, 0, 0, D, 0, 0, 0, 0,  0, W, 8'h02, 8'h02, L, 1, 0, 0};
    tbl[8]  = '{1, 7, 0, D, 0, 0, 0, 0,  1, N, 8'h00, 8'h00, L, 0, 0, 0};
    tbl[9]  = '{1, 3, 3, L, 0, 0, 0, 0,  0, W, 8'h80, 8'h01, D, 1, 0, 0};
    tbl[10] = '{1, 3, 3, L, 0, 0, 0, 0,  1, N, 8'h00, 8'h00, D, 0, 0, 0};
    tbl[11] = '{0, 0, 0, D, 0, 0, 0, 0,  0, W, 8'h08, 8'h08, L, 1, 0, 0};
    tbl[12] = '{0, 0, 0, D, 1, 1, 0, 0,  0, N, 8'h00, 8'h00, L, 0, 0, 0};
    tbl[13] = '{0, 0, 0, D, 0, 0, 0, 0,  0, W, 8'hFF, 8'hFF, D, 1, 0, 0};
    tbl[14] = '{1, 4, 4, L, 0, 1, 1, 0,  0, N, 8'h00, 8'h00, D, 0, 0, 0};
    tbl[15] = '{0, 0, 0, D, 0, 0, 0, 0,  0, P, 8'h00, 8'h00, D, 1, 0, 0};
    tbl[16] = '{0, 0, 0, D, 0, 1, 0, 0,  0, N, 8'h00, 8'h00, D, 1, 1, 1};
    tbl[17] = '{0, 0, 0, D, 0, 0, 0, 0,  1, N, 8'h00, 8'h00, D, 0, 0, 1};

    idle_inputs();
    rd_row = '0; rd_col = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outputs", pk(wr_ready, cmd, rsel_i, csel_i, state_in, busy, done, gen_count),
        pk(1'b1, N, 8'h00, 8'h00, D, 1'b0, 1'b0, 16'd0));
    chk("reset_stable", 64'(stable), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      rd_row = 3'(i); rd_col = 3'(7 - i);
      #1;
      chk("read_decode", 64'({rsel_o, csel_o}), 64'({8'(1 << i), 8'(1 << (7 - i))}));
    end

    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      wr_valid = tbl[k].wv; wr_row = tbl[k].row; wr_col = tbl[k].col; wr_state = tbl[k].ws;
      clear = tbl[k].clr; start = tbl[k].st; num_gens = tbl[k].ng; period = tbl[k].per;
      #1;
      chk($sformatf("vec%0d", k),
          pk(wr_ready, cmd, rsel_i, csel_i, state_in, busy, done, gen_count),
          pk(tbl[k].e_rdy, tbl[k].e_cmd, tbl[k].e_rsel, tbl[k].e_csel, tbl[k].e_sin,
             tbl[k].e_busy, tbl[k].e_done, tbl[k].e_gen));
    end
    idle_inputs();

    // 3 generations with a 2-cycle gap
    kick(16'd3, 24'd2);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) next_cycle();
      chk($sformatf("gap_cmd%0d", i), 64'(cmd), 64'(seq_a[i]));
    end
    next_cycle();
    chk("gap_done", 64'({done, busy, cmd, gen_count}), 64'({1'b1, 1'b1, N, 16'd3}));
    next_cycle();
    chk("gap_idle", 64'({done, busy, gen_count}), 64'({1'b0, 1'b0, 16'd3}));

    // unlimited run stopped during the 5th PROCESS cycle
    kick(16'd0, 24'd0);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        @(negedge clk);
        if (i == 4) stop = 1'b1;
        #1;
      end
      chk($sformatf("stop_cmd%0d", i), 64'(cmd), 64'(P));
    end
    @(negedge clk);
    stop = 1'b0;
    #1;
    chk("stop_done", 64'({done, cmd, gen_count}), 64'({1'b1, N, 16'd5}));
    next_cycle();
    chk("stop_idle", 64'(busy), 64'd0);

    // async reset in WAIT, then a fresh run
    kick(16'd10, 24'd3);
    next_cycle();
    chk("pre_reset", 64'({busy, cmd, gen_count}), 64'({1'b1, N, 16'd1}));
    rst_n = 1'b0;
    #1;
    chk("mid_reset", 64'({busy, cmd, gen_count}), 64'({1'b0, N, 16'd0}));
    @(negedge clk);
    rst_n = 1'b1;
    kick(16'd2, 24'd1);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) next_cycle();
      chk($sformatf("rerun_cmd%0d", i), 64'(cmd), 64'(seq_c[i]));
    end
    next_cycle();
    chk("rerun_done", 64'({done, gen_count}), 64'({1'b1, 16'd2}));

    // inactive array, 100 generations requested
    next_cycle();
    any_active = 1'b0;
    kick(16'd100, 24'd0);
    chk("inact_first", 64'(cmd), 64'(P));
`ifdef PE_CTL_STABLE_STOP_EN
    next_cycle();
    chk("inact_stop", 64'({done, stable, gen_count}), 64'({1'b1, 1'b1, 16'd1}));
`else
    nproc = 1;
    seen = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      next_cycle();
      if (done) seen = 1'b1;
      else if (cmd == P) nproc++;
    end
    chk("inact_done_seen", 64'(seen), 64'd1);
    chk("inact_nproc", 64'(nproc), 64'd100);
    chk("inact_end", 64'({stable, gen_count}), 64'({1'b0, 16'd100}));
`endif
    idle_inputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
